line_buffer_ctrl: RTL
=====================

# line_buffer_ctrl

Sequencing controller for the ping-pong line-doubling buffers between the PPU pixel stream and the VGA scan-out. Locks to the PPU line-start pulse and generates the write address and per-buffer write enables at half the PPU rate. Swaps writer and reader buffers every PPU line and releases the VGA timing generator (`vga_en`) once two lines have been buffered. Detects loss of line alignment and re-synchronises.

## Interface
- `PPU_LINE_CLKS`, default 1600: clocks per PPU line.
- `STARTUP_DELAY`, default 3201: clocks from lock to `vga_en` rising (two lines plus pipeline, minus one).
- `ADDR_W`, default 10: buffer address width.
- `clk`  in  1  pixel clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ppu_line_start`  in  1  one-cycle pulse in the cycle the PPU x counter equals 0.
- `wr_addr`  out  ADDR_W  buffer write address, 0..PPU_LINE_CLKS/2-1.
- `buf_a_we`  out  1  write enable, buffer A.
- `buf_b_we`  out  1  write enable, buffer B.
- `wr_sel`  out  1  0 = writing A, 1 = writing B.
- `rd_sel`  out  1  buffer the VGA side reads; always `~wr_sel` while locked.
- `vga_en`  out  1  level; starts/holds the VGA h/v counters.
- `sync_err`  out  1  sticky alignment-error flag.

## Operation
- Internal counters:
  - `x_cnt` (11 b): 0..PPU_LINE_CLKS-1, wraps to 0.
  - `st_cnt` (12 b): saturates at STARTUP_DELAY.
- State WAIT_SYNC (reset state):
  - Counters held at 0; all outputs 0.
  - On `ppu_line_start`: go to FILL. Next cycle `x_cnt`=0, `st_cnt`=0, `wr_sel`=0.
- State FILL:
  - `x_cnt` increments every clock; `st_cnt` increments every clock.
  - When `st_cnt`==STARTUP_DELAY-1: `vga_en`<=1, go to RUN.
- State RUN: as FILL; `st_cnt` frozen; `vga_en` held at 1.
- Write sequencing (FILL and RUN):
  - Write strobe active when `x_cnt[0]`==0.
  - `wr_addr` = `x_cnt`>>1.
  - `buf_a_we` = strobe & ~`wr_sel`; `buf_b_we` = strobe & `wr_sel`.
  - The two enables are never both 1.
- Buffer swap:
  - When `x_cnt` wraps PPU_LINE_CLKS-1 -> 0, `wr_sel` toggles in the same edge.
  - `rd_sel` = `~wr_sel`, updated in the same edge.
- Alignment check (FILL and RUN):
  - Aligned pulse: `ppu_line_start` sampled while `x_cnt`==PPU_LINE_CLKS-1. No action.
  - Misaligned pulse (any other `x_cnt`):
    - `sync_err`<=1, `vga_en`<=0.
    - `x_cnt`<=0, `st_cnt`<=0, `wr_sel`<=0; state<=FILL (immediate relock).
  - Missing pulse (wrap with no pulse present):
    - `sync_err`<=1.
    - Free-running continues; no state change; `vga_en` unchanged.
- `sync_err` clears only on `rst`.

## Timing
- Reset values: `wr_addr`=0, `buf_a_we`=0, `buf_b_we`=0, `wr_sel`=0, `rd_sel`=0, `vga_en`=0, `sync_err`=0, state WAIT_SYNC.
- All outputs registered; one-cycle latency from `ppu_line_start` to `x_cnt`=0 and first write (`wr_addr`=0, `buf_a_we`=1).
- `vga_en` rises exactly STARTUP_DELAY cycles after the first `x_cnt`=0 cycle.
- Write rate: 800 writes per line, addresses 0,1,...,799, one every second clock.
- Simultaneous `rst` and `ppu_line_start`: `rst` wins; the pulse is ignored.
- `rst` mid-operation: all outputs return to reset values at the next edge; relock requires a new pulse.
- Misaligned pulse that coincides with a buffer wrap: treated as misaligned, `wr_sel` forced to 0 (no toggle).

## Test plan
- Reset, then pulses every 1600 clocks -> `buf_a_we` on even cycles with `wr_addr` 0..799; `wr_sel` toggles 0->1->0 at each wrap; `rd_sel`=~`wr_sel`; `vga_en`=1 at 3201 cycles after first `x_cnt`=0; `sync_err`=0 throughout.
- In RUN, inject an extra pulse at `x_cnt`=700 -> next cycle `sync_err`=1, `vga_en`=0, `wr_addr`=0, `wr_sel`=0, `buf_a_we`=1; `vga_en` re-rises 3201 cycles later.
- Suppress one line-start pulse in RUN -> `sync_err`=1 at the wrap; `wr_sel` still toggles; `vga_en` stays 1; `wr_addr` continues 0..799.
- Assert `rst` for one cycle at `x_cnt`=1234 in RUN -> all outputs 0 next cycle; no writes until the next pulse, then the first write is at `wr_addr`=0.
- Assert `rst` and `ppu_line_start` in the same cycle -> remains in WAIT_SYNC, `buf_a_we`=`buf_b_we`=0; the next lone pulse locks.
- Over 10 lines, assert every cycle that `buf_a_we & buf_b_we`==0 and that no write occurs on odd `x_cnt`.

Source files
------------

// File: rtl/line_buffer_if.sv
// ============================================================================
// line_buffer_if
// ----------------------------------------------------------------------------
// Signal bundle between the PPU-side line timing, the line buffer controller
// and the ping-pong line buffers / VGA timing generator.
//
//   ppu_line_start  one-cycle pulse while the PPU x counter equals 0
//   wr_addr         buffer write address (x_cnt >> 1)
//   buf_a_we        write enable, buffer A
//   buf_b_we        write enable, buffer B
//   wr_sel          0 = writing A, 1 = writing B
//   rd_sel          buffer read by the VGA side
//   vga_en          level that starts/holds the VGA h/v counters
//   sync_err        sticky line-alignment error flag
//
// master : the controller (consumes ppu_line_start, drives everything else)
// slave  : the environment (drives ppu_line_start, observes the rest)
// ============================================================================
interface line_buffer_if #(
    parameter int ADDR_W = 10
);
    logic              ppu_line_start;
    logic [ADDR_W-1:0] wr_addr;
    logic              buf_a_we;
    logic              buf_b_we;
    logic              wr_sel;
    logic              rd_sel;
    logic              vga_en;
    logic              sync_err;

    modport master (
        input  ppu_line_start,
        output wr_addr,
        output buf_a_we,
        output buf_b_we,
        output wr_sel,
        output rd_sel,
        output vga_en,
        output sync_err
    );

    modport slave (
        output ppu_line_start,
        input  wr_addr,
        input  buf_a_we,
        input  buf_b_we,
        input  wr_sel,
        input  rd_sel,
        input  vga_en,
        input  sync_err
    );
endinterface

// File: rtl/line_buffer_ctrl.sv
// ============================================================================
// line_buffer_ctrl
// ----------------------------------------------------------------------------
// Sequencing controller for the ping-pong line-doubling buffers that sit
// between the PPU pixel stream and the VGA scan-out.
//
// Locks to the PPU line-start pulse, then walks an x counter over the PPU
// line. Every second clock it writes one pixel at address x_cnt>>1 into the
// buffer selected by wr_sel. At each line wrap the writer and reader buffers
// swap. Once two lines plus pipeline slack have been buffered, vga_en is
// raised to release the VGA timing generator.
//
// Alignment is checked on every line-start pulse: a pulse anywhere but the
// last x position relocks immediately and restarts the fill; a wrap with no
// pulse only flags the error and keeps free-running.
//
// Ports:
//   clk   pixel clock, all logic on the rising edge
//   rst   synchronous, active-high reset
//   lb    line_buffer_if.master (see the interface for signal meanings)
//
// Parameters:
//   PPU_LINE_CLKS  clocks per PPU line
//   STARTUP_DELAY  clocks from the first x_cnt==0 cycle to vga_en rising
//   ADDR_W         buffer address width
// ============================================================================
module line_buffer_ctrl #(
    parameter int PPU_LINE_CLKS = 1600,
    parameter int STARTUP_DELAY = 3201,
    parameter int ADDR_W        = 10
) (
    input  logic          clk,
    input  logic          rst,
    line_buffer_if.master lb
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        FILL      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [10:0] X_LAST  = 11'(PPU_LINE_CLKS - 1);
    localparam logic [11:0] ST_LAST = 12'(STARTUP_DELAY - 1);

    // Registered state.
    state_t      state;
    logic [10:0] x_cnt;
    logic [11:0] st_cnt;
    logic        wr_sel_q;
    logic        vga_en_q;
    logic        sync_err_q;

    // Next-state values.
    state_t      state_n;
    logic [10:0] x_n;
    logic [11:0] st_n;
    logic        wr_sel_n;
    logic        vga_en_n;
    logic        sync_err_n;

    // Output decode of the next state, registered alongside it so every
    // output is a flop while still tracking x_cnt cycle-for-cycle.
    logic        locked_n;
    logic        strobe_n;

    logic        at_wrap;
    logic        misaligned;

    assign at_wrap    = (x_cnt == X_LAST);
    // Any pulse away from the last x position means the PPU line started
    // somewhere we did not expect.
    assign misaligned = lb.ppu_line_start && !at_wrap;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        x_n        = x_cnt;
        st_n       = st_cnt;
        wr_sel_n   = wr_sel_q;
        vga_en_n   = vga_en_q;
        sync_err_n = sync_err_q;

        case (state)
            WAIT_SYNC: begin
                // Counters held at zero until the first line-start pulse.
                x_n      = '0;
                st_n     = '0;
                wr_sel_n = 1'b0;
                vga_en_n = 1'b0;
                if (lb.ppu_line_start) begin
                    state_n = FILL;
                end
            end

            default: begin
                if (misaligned) begin
                    // Immediate relock: the pulse just seen becomes x = 0.
                    // This takes priority over a coincident wrap, so wr_sel
                    // is forced to A rather than toggled.
                    sync_err_n = 1'b1;
                    vga_en_n   = 1'b0;
                    x_n        = '0;
                    st_n       = '0;
                    wr_sel_n   = 1'b0;
                    state_n    = FILL;
                end else begin
                    if (at_wrap) begin
                        x_n      = '0;
                        wr_sel_n = !wr_sel_q;
                        // Wrap without a pulse: keep free-running, flag it.
                        if (!lb.ppu_line_start) begin
                            sync_err_n = 1'b1;
                        end
                    end else begin
                        x_n = x_cnt + 11'd1;
                    end

                    // Startup counter only advances while filling; once in
                    // RUN it stays frozen at STARTUP_DELAY.
                    if (state == FILL) begin
                        st_n = st_cnt + 12'd1;
                        if (st_cnt == ST_LAST) begin
                            vga_en_n = 1'b1;
                            state_n  = RUN;
                        end
                    end
                end
            end
        endcase
    end

    assign locked_n = (state_n != WAIT_SYNC);
    assign strobe_n = locked_n && !x_n[0];

    // NOTE: sequential state is written only with non-blocking assignments,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins over a coincident ppu_line_start.
            state       <= WAIT_SYNC;
            x_cnt       <= '0;
            st_cnt      <= '0;
            wr_sel_q    <= 1'b0;
            vga_en_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            lb.wr_addr  <= '0;
            lb.buf_a_we <= 1'b0;
            lb.buf_b_we <= 1'b0;
            lb.wr_sel   <= 1'b0;
            lb.rd_sel   <= 1'b0;
            lb.vga_en   <= 1'b0;
            lb.sync_err <= 1'b0;
        end else begin
            state       <= state_n;
            x_cnt       <= x_n;
            st_cnt      <= st_n;
            wr_sel_q    <= wr_sel_n;
            vga_en_q    <= vga_en_n;
            sync_err_q  <= sync_err_n;
            lb.wr_addr  <= ADDR_W'(x_n >> 1);
            lb.buf_a_we <= strobe_n && !wr_sel_n;
            lb.buf_b_we <= strobe_n &&  wr_sel_n;
            lb.wr_sel   <= wr_sel_n;
            // The reader is the buffer not being written, but only once
            // locked; in WAIT_SYNC every output sits at 0.
            lb.rd_sel   <= locked_n && !wr_sel_n;
            lb.vga_en   <= vga_en_n;
            lb.sync_err <= sync_err_n;
        end
    end

    // Both buffers must never be written in the same cycle.
    a_we_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(lb.buf_a_we && lb.buf_b_we));

endmodule
